sr_latch_driver: RTL

Clocked write-side controller for a bank of gated SR latches (the sr_latch block). Converts a valid/ready write request (data + bit mask) into a legal, timed s/r/enable sequence with setup, enable-pulse and hold phases. Also issues timed latch clears. Optionally reads back the latch q outputs to confirm each write.

---
 rtl/sr_latch_driver_if.sv | 30 +++
 rtl/sr_latch_driver.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver_if.sv
// sr_latch_driver_if: request side and latch-bank side of the SR latch
// write driver, bundled into one interface.
// master: the requester / latch-bank model (drives requests and q).
// slave : the driver itself (drives handshake, s/r/enable, latch_reset, status).
interface sr_latch_driver_if #(
  parameter int WIDTH = 1
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] req_mask;
  logic             clr_req;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             enable;
  logic             latch_reset;
  logic [WIDTH-1:0] q;
  logic             done;
  logic             err;

  modport master (
    output req_valid, req_data, req_mask, clr_req, q,
    input  req_ready, s, r, enable, latch_reset, done, err
  );

  modport slave (
    input  req_valid, req_data, req_mask, clr_req, q,
    output req_ready, s, r, enable, latch_reset, done, err
  );
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns a masked write request into a timed
// setup / enable-pulse / hold sequence on a bank of gated SR latches,
// and issues timed bank clears through latch_reset.
// Optional feature macro: SR_DRV_READBACK_EN -- when defined, the latch
// q outputs are compared against the written bits at the end of HOLD and
// a mismatch sets the sticky err flag together with done.
module sr_latch_driver #(
  parameter int WIDTH     = 1,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                reset,
  sr_latch_driver_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK,
    CLEAR
  } state_t;

  // Phase counters load N-1 on entry and leave the phase when they hit 0.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] r_q;
  logic             en_q;
  logic             lr_q;
  logic             rdy_q;
  logic             done_q;
  logic             err_q;

  logic             accept_d;
  logic             cnt_zero_d;
  logic             rb_fail_d;

  // A clear in the same cycle as a write request takes priority, so the
  // write is only taken when no clear is being requested.
  always_comb begin
    accept_d   = bus.req_valid && rdy_q && !bus.clr_req;
    cnt_zero_d = (cnt_q == 8'd0);
  end

`ifdef SR_DRV_READBACK_EN
  // Readback compare, sampled in the last HOLD cycle so err lands with done.
  always_comb begin
    rb_fail_d = |((bus.q ^ data_q) & mask_q);
  end
`else
  // Without readback the captured request and q are not consumed.
  logic unused_rb;
  assign unused_rb = ^{bus.q, data_q, mask_q};
  assign rb_fail_d = 1'b0;
`endif

  // Write/clear sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      data_q  <= '0;
      mask_q  <= '0;
      s_q     <= '0;
      r_q     <= '0;
      en_q    <= 1'b0;
      lr_q    <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          lr_q <= 1'b0;
          if (bus.clr_req) begin
            state_q <= CLEAR;
            cnt_q   <= PULSE_LD;
            lr_q    <= 1'b1;
            rdy_q   <= 1'b0;
          end else if (accept_d) begin
            state_q <= SETUP;
            cnt_q   <= SETUP_LD;
            data_q  <= bus.req_data;
            mask_q  <= bus.req_mask;
            // Disjoint by construction: a bit is either set, reset or untouched.
            s_q     <= bus.req_data & bus.req_mask;
            r_q     <= ~bus.req_data & bus.req_mask;
            rdy_q   <= 1'b0;
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_zero_d) begin
            state_q <= PULSE;
            cnt_q   <= PULSE_LD;
            en_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        PULSE: begin
          if (cnt_zero_d) begin
            state_q <= HOLD;
            cnt_q   <= HOLD_LD;
            en_q    <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        HOLD: begin
          if (cnt_zero_d) begin
            state_q <= CHECK;
            cnt_q   <= 8'd0;
            s_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b1;
            if (rb_fail_d) err_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        CHECK: begin
          // Shared completion cycle for writes and clears.
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
        CLEAR: begin
          if (cnt_zero_d) begin
            state_q <= CHECK;
            cnt_q   <= 8'd0;
            lr_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
          s_q     <= '0;
          r_q     <= '0;
          en_q    <= 1'b0;
          lr_q    <= 1'b1;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = rdy_q;
  assign bus.s           = s_q;
  assign bus.r           = r_q;
  assign bus.enable      = en_q;
  assign bus.latch_reset = lr_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
